// File: rtl/hazard_scoreboard.sv
// Consumer-side hazard controller: tracks in-flight destinations/Tnew in EX, MEM, WB,
// resolves stall and forwarding source for the ID instruction, and owns the mult/div busy counter.
module hazard_scoreboard #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic [6:0] id_rs_ura,
  input  logic [6:0] id_rt_ura,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  input  logic [1:0] id_rs_tuse,
  input  logic [1:0] id_rt_tuse,
  input  logic [6:0] id_rd_ura,
  input  logic [1:0] id_tnew,
  input  logic       id_md_start,
  input  logic       id_md_div,
  input  logic       id_md_access,
  output logic       stall,
  output logic [1:0] fwd_rs_sel,
  output logic [1:0] fwd_rt_sel,
  output logic [6:0] ex_rd_ura,
  output logic [6:0] mem_rd_ura,
  output logic [6:0] wb_rd_ura,
  output logic [1:0] ex_tnew,
  output logic [1:0] mem_tnew,
  output logic       md_busy
);

  logic [1:0] wb_tnew;
  logic [3:0] md_count;
  logic [2:0] rs_res;
  logic [2:0] rt_res;
  logic       md_stall;

  function automatic logic [1:0] sat_dec(input logic [1:0] x);
    return (x == 2'd0) ? 2'd0 : x - 2'd1;
  endfunction

  // Returns {stall, sel}; the youngest matching stage wins, older matches are ignored.
  function automatic logic [2:0] src_check(
    input logic       used,
    input logic [6:0] ura,
    input logic [1:0] tuse,
    input logic [6:0] e_ura,
    input logic [1:0] e_tnew,
    input logic [6:0] m_ura,
    input logic [1:0] m_tnew,
    input logic [6:0] w_ura,
    input logic [1:0] w_tnew
  );
    logic [2:0] res;
    res = 3'b000;
    if (used && ura != 7'h00 && ura != 7'h2F) begin
      if (e_ura == ura)      res = {e_tnew > tuse, 2'b01};
      else if (m_ura == ura) res = {m_tnew > tuse, 2'b10};
      else if (w_ura == ura) res = {w_tnew > tuse, 2'b11};
    end
    return res;
  endfunction

  always_comb begin
    rs_res = src_check(id_rs_used, id_rs_ura, id_rs_tuse, ex_rd_ura, ex_tnew,
                       mem_rd_ura, mem_tnew, wb_rd_ura, wb_tnew);
    rt_res = src_check(id_rt_used, id_rt_ura, id_rt_tuse, ex_rd_ura, ex_tnew,
                       mem_rd_ura, mem_tnew, wb_rd_ura, wb_tnew);
    md_stall   = (id_md_access | id_md_start) & md_busy;
    stall      = !reset & (rs_res[2] | rt_res[2] | md_stall);
    fwd_rs_sel = reset ? 2'b00 : rs_res[1:0];
    fwd_rt_sel = reset ? 2'b00 : rt_res[1:0];
  end

  assign md_busy = (md_count != 4'd0);

  // EX/MEM/WB always advance; only the entry into EX and EX->MEM can be squashed.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_rd_ura  <= '0;
      ex_tnew    <= '0;
      mem_rd_ura <= '0;
      mem_tnew   <= '0;
      wb_rd_ura  <= '0;
      wb_tnew    <= '0;
      md_count   <= '0;
    end else begin
      if (flush || stall) begin
        ex_rd_ura <= '0;
        ex_tnew   <= '0;
      end else begin
        ex_rd_ura <= id_rd_ura;
        ex_tnew   <= id_tnew;
      end
      if (flush) begin
        mem_rd_ura <= '0;
        mem_tnew   <= '0;
      end else begin
        mem_rd_ura <= ex_rd_ura;
        mem_tnew   <= sat_dec(ex_tnew);
      end
      wb_rd_ura <= mem_rd_ura;
      wb_tnew   <= sat_dec(mem_tnew);
      // A started mult/div runs to completion even across a flush.
      if (id_md_start && !stall && !flush)
        md_count <= id_md_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
      else if (md_count != 4'd0)
        md_count <= md_count - 4'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed hazard scenarios plus random traffic,
// checked against an instruction-age reference model.
module tb_hazard_scoreboard;

  logic       clk;
  logic       reset;
  logic       flush;
  logic [6:0] id_rs_ura, id_rt_ura, id_rd_ura;
  logic       id_rs_used, id_rt_used;
  logic [1:0] id_rs_tuse, id_rt_tuse, id_tnew;
  logic       id_md_start, id_md_div, id_md_access;
  logic       stall;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;
  logic [6:0] ex_rd_ura, mem_rd_ura, wb_rd_ura;
  logic [1:0] ex_tnew, mem_tnew;
  logic       md_busy;

  hazard_scoreboard #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .id_rs_ura(id_rs_ura), .id_rt_ura(id_rt_ura),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_rs_tuse(id_rs_tuse), .id_rt_tuse(id_rt_tuse),
    .id_rd_ura(id_rd_ura), .id_tnew(id_tnew),
    .id_md_start(id_md_start), .id_md_div(id_md_div), .id_md_access(id_md_access),
    .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .ex_rd_ura(ex_rd_ura), .mem_rd_ura(mem_rd_ura), .wb_rd_ura(wb_rd_ura),
    .ex_tnew(ex_tnew), .mem_tnew(mem_tnew), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: each in-flight instruction remembers its original Tnew and how many
  // edges it has been past ID (1 = EX, 2 = MEM, 3 = WB).
  typedef struct {
    logic [6:0] ura;
    int         tnew0;
    int         age;
  } inst_t;

  inst_t pipe[$];
  int    cyc = 0;
  int    md_done = 0;
  int    errors = 0;
  int    checks = 0;

  logic       exp_stall, exp_busy;
  logic [1:0] exp_rs, exp_rt;

  function automatic int remaining(input inst_t e);
    int r;
    r = e.tnew0 - (e.age - 1);
    return (r < 0) ? 0 : r;
  endfunction

  function automatic int stage_ura(input int age);
    foreach (pipe[i]) if (pipe[i].age == age) return int'(pipe[i].ura);
    return 0;
  endfunction

  function automatic int stage_tnew(input int age);
    foreach (pipe[i]) if (pipe[i].age == age) return remaining(pipe[i]);
    return 0;
  endfunction

  task automatic eval_src(input logic used, input logic [6:0] ura, input logic [1:0] tuse,
                          output logic [1:0] code, output logic st);
    int best, rem;
    best = 4; rem = 0; code = 2'b00; st = 1'b0;
    if (used && ura != 7'h00 && ura != 7'h2F)
      foreach (pipe[i])
        if (pipe[i].ura == ura && pipe[i].age < best) begin
          best = pipe[i].age;
          rem  = remaining(pipe[i]);
        end
    if (best < 4) begin
      code = 2'(best);
      st   = (rem > int'(tuse));
    end
  endtask

  task automatic eval();
    logic s_rs, s_rt, s_md;
    eval_src(id_rs_used, id_rs_ura, id_rs_tuse, exp_rs, s_rs);
    eval_src(id_rt_used, id_rt_ura, id_rt_tuse, exp_rt, s_rt);
    exp_busy  = (cyc < md_done);
    s_md      = (id_md_access || id_md_start) && exp_busy;
    exp_stall = !reset && (s_rs || s_rt || s_md);
    if (reset) begin
      exp_rs = 2'b00;
      exp_rt = 2'b00;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic checkOutput();
    #1;
    eval();
    chk("stall",      32'(stall),      32'(exp_stall));
    chk("fwd_rs_sel", 32'(fwd_rs_sel), 32'(exp_rs));
    chk("fwd_rt_sel", 32'(fwd_rt_sel), 32'(exp_rt));
    chk("ex_rd_ura",  32'(ex_rd_ura),  32'(stage_ura(1)));
    chk("ex_tnew",    32'(ex_tnew),    32'(stage_tnew(1)));
    chk("mem_rd_ura", 32'(mem_rd_ura), 32'(stage_ura(2)));
    chk("mem_tnew",   32'(mem_tnew),   32'(stage_tnew(2)));
    chk("wb_rd_ura",  32'(wb_rd_ura),  32'(stage_ura(3)));
    chk("md_busy",    32'(md_busy),    32'(exp_busy));
  endtask

  // One clock edge, with the model advanced from the inputs held across it.
  task automatic step();
    inst_t e;
    eval();
    @(posedge clk);
    if (reset) begin
      pipe.delete();
      md_done = 0;
    end else begin
      if (id_md_start && !exp_stall && !flush)
        md_done = cyc + 1 + (id_md_div ? 10 : 5);
      for (int i = pipe.size() - 1; i >= 0; i--)
        if (flush && pipe[i].age == 1) pipe.delete(i);
      foreach (pipe[i]) pipe[i].age++;
      for (int i = pipe.size() - 1; i >= 0; i--)
        if (pipe[i].age > 3) pipe.delete(i);
      if (!flush && !exp_stall) begin
        e.ura = id_rd_ura; e.tnew0 = int'(id_tnew); e.age = 1;
        pipe.push_back(e);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic applyStimulus(input logic [6:0] rs, input logic [1:0] rs_tuse,
                               input logic [6:0] rt, input logic [1:0] rt_tuse,
                               input logic [6:0] rd, input logic [1:0] tnew);
    id_rs_ura = rs; id_rs_used = (rs != 7'h00); id_rs_tuse = rs_tuse;
    id_rt_ura = rt; id_rt_used = (rt != 7'h00); id_rt_tuse = rt_tuse;
    id_rd_ura = rd; id_tnew = tnew;
    id_md_start = 1'b0; id_md_div = 1'b0; id_md_access = 1'b0;
    flush = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput();
      step();
    end
  endtask

  // Checks every cycle while the ID instruction is held; n = stall cycles seen.
  task automatic runUntilFree(output int n);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      checkOutput();
      if (stall !== 1'b1) break;
      n++;
      step();
    end
  endtask

  int n;

  initial begin
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput();
    step();
    reset = 1'b0;
    checkOutput();
    chk("reset_ex_ura", 32'(ex_rd_ura), 32'd0);
    chk("reset_md_busy", 32'(md_busy), 32'd0);

    $display("[TB] load-use, tuse 0");
    applyStimulus(0, 0, 0, 0, 7'd2, 2'd2);
    checkOutput(); step();
    applyStimulus(7'd2, 0, 0, 0, 7'd4, 2'd1);
    checkOutput();
    chk("lw_first_fwd", 32'(fwd_rs_sel), 32'd1);
    runUntilFree(n);
    chk("lw_stall_cycles", 32'(n), 32'd2);
    chk("lw_free_fwd", 32'(fwd_rs_sel), 32'd3);
    step(); idle(3);

    $display("[TB] alu producer, tuse 0 and tuse 1");
    applyStimulus(0, 0, 0, 0, 7'd3, 2'd1);
    checkOutput(); step();
    applyStimulus(7'd3, 0, 0, 0, 0, 0);
    runUntilFree(n);
    chk("alu_stall_cycles", 32'(n), 32'd1);
    chk("alu_free_fwd", 32'(fwd_rs_sel), 32'd2);
    step(); idle(3);
    applyStimulus(0, 0, 0, 0, 7'd3, 2'd1);
    checkOutput(); step();
    applyStimulus(0, 0, 7'd3, 2'd1, 0, 0);
    checkOutput();
    chk("tuse1_stall", 32'(stall), 32'd0);
    chk("tuse1_fwd", 32'(fwd_rt_sel), 32'd1);
    step(); idle(3);

    $display("[TB] youngest producer wins");
    applyStimulus(0, 0, 0, 0, 7'd3, 2'd1);
    checkOutput(); step();
    applyStimulus(0, 0, 0, 0, 7'd3, 2'd0);
    checkOutput(); step();
    applyStimulus(7'd3, 0, 0, 0, 0, 0);
    checkOutput();
    chk("youngest_fwd", 32'(fwd_rs_sel), 32'd1);
    chk("youngest_stall", 32'(stall), 32'd0);
    step(); idle(3);

    $display("[TB] mult/div busy");
    applyStimulus(0, 0, 0, 0, 0, 0);
    id_md_start = 1'b1;
    checkOutput(); step();
    applyStimulus(0, 0, 0, 0, 7'd5, 2'd1);
    id_md_access = 1'b1;
    runUntilFree(n);
    chk("mult_stall_cycles", 32'(n), 32'd5);
    step(); idle(2);
    applyStimulus(0, 0, 0, 0, 0, 0);
    id_md_start = 1'b1; id_md_div = 1'b1;
    checkOutput(); step();
    applyStimulus(0, 0, 0, 0, 7'd5, 2'd1);
    id_md_access = 1'b1;
    runUntilFree(n);
    chk("div_stall_cycles", 32'(n), 32'd10);
    step(); idle(2);

    $display("[TB] flush over stall, counter keeps running");
    applyStimulus(0, 0, 0, 0, 0, 0);
    id_md_start = 1'b1;
    checkOutput(); step();
    applyStimulus(0, 0, 0, 0, 7'd2, 2'd2);
    checkOutput(); step();
    applyStimulus(7'd2, 0, 0, 0, 7'd4, 2'd1);
    checkOutput();
    chk("pre_flush_stall", 32'(stall), 32'd1);
    flush = 1'b1;
    checkOutput(); step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput();
    chk("flush_mem_ura", 32'(mem_rd_ura), 32'd0);
    chk("flush_stall", 32'(stall), 32'd0);
    chk("flush_md_busy", 32'(md_busy), 32'd1);
    step(); idle(5);

    $display("[TB] URA 0 and 2F never match");
    applyStimulus(0, 0, 0, 0, 7'h2F, 2'd2);
    checkOutput(); step();
    applyStimulus(0, 0, 0, 0, 7'h00, 2'd2);
    checkOutput(); step();
    applyStimulus(7'h2F, 0, 7'h00, 0, 0, 0);
    id_rt_used = 1'b1;
    checkOutput();
    chk("ura_special_stall", 32'(stall), 32'd0);
    chk("ura_special_fwd", 32'({fwd_rs_sel, fwd_rt_sel}), 32'd0);
    step(); idle(3);

    $display("[TB] reset mid-stall");
    applyStimulus(0, 0, 0, 0, 0, 0);
    id_md_start = 1'b1;
    checkOutput(); step();
    applyStimulus(0, 0, 0, 0, 7'd2, 2'd2);
    checkOutput(); step();
    applyStimulus(0, 0, 7'd2, 0, 7'd4, 2'd1);
    checkOutput();
    chk("pre_reset_stall", 32'(stall), 32'd1);
    reset = 1'b1;
    checkOutput();
    chk("reset_forces_stall", 32'(stall), 32'd0);
    step();
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput();
    chk("post_reset_all", 32'({ex_rd_ura, mem_rd_ura, wb_rd_ura, ex_tnew, mem_tnew, md_busy}), 32'd0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      logic [6:0] pool [5];
      pool[0] = 7'h00; pool[1] = 7'h01; pool[2] = 7'h02; pool[3] = 7'h03; pool[4] = 7'h2F;
      id_rs_ura    = pool[$urandom_range(4)];
      id_rt_ura    = pool[$urandom_range(4)];
      id_rd_ura    = pool[$urandom_range(4)];
      id_rs_used   = 1'($urandom);
      id_rt_used   = 1'($urandom);
      id_rs_tuse   = 2'($urandom);
      id_rt_tuse   = 2'($urandom);
      id_tnew      = 2'($urandom);
      id_md_start  = ($urandom_range(9) == 0);
      id_md_div    = 1'($urandom);
      id_md_access = ($urandom_range(9) == 0);
      flush        = ($urandom_range(9) == 0);
      reset        = ($urandom_range(49) == 0);
      checkOutput();
      step();
    end
    reset = 1'b0;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
